enc: RTL and testbench
======================

Name: enc

Overview:
- RV32I instruction encoder. Converts a decoded micro-op back into a 32-bit instruction word; it is the inverse of the team's instruction decoder.
- Used by the self-test program loader and the trace-replay path to produce instruction words for instruction memory.
- Requests are accepted over a valid/ready input. Each legal request is encoded in one cycle and buffered in an output FIFO with valid/ready.
- Requests that cannot be encoded are dropped and counted.

Parameters:
DEPTH, 4, output FIFO depth in words (power of two, ≥2)
ERR_W, 16, width of the illegal-request counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request
op_class  in  3  0 CALC_IMM, 1 CALC_REG, 2 LOAD, 3 STORE, 4 LUI, 5 JALR, 6 ENV, 7 reserved
alu_op  in  4  {sub/arith bit, funct3}
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  32  full-width immediate value
mem_size  in  2  00 byte, 01 half, 10 word
is_mem_sign  in  1  load sign-extend
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_inst  out  32  FIFO head instruction word
enc_err  out  1  one-cycle pulse when an illegal request is dropped
err_count  out  ERR_W  count of dropped requests, wraps

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_inst=0, enc_err=0, err_count=0; FIFO emptied.
- Reset asserted mid-transfer discards all buffered words and any in-flight request.
- Accept: in_valid&&in_ready. in_ready = !full, taken from registered occupancy. There is no combinational path from out_ready to in_ready.
- A push while full is never possible. When full, a same-cycle pop does not enable a push.
- Latency: a word accepted in cycle N appears at out_valid/out_inst in cycle N+1 if the FIFO was empty.
- FIFO order is strict; there is no bypass.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits.
- out_inst is held stable while out_valid&&!out_ready.
- Encoding: f3=alu_op[2:0]; I-imm=imm[11:0]; S-imm split is imm[11:5]→[31:25], imm[4:0]→[11:7].
  - CALC_IMM: opcode 0010011. For f3=001 or 101: inst[31:25]={0,alu_op[3],00000}, inst[24:20]=imm[4:0]. Otherwise inst[31:20]=imm[11:0].
  - CALC_REG: opcode 0110011, {0,alu_op[3],00000,rs2,rs1,f3,rd}.
  - LOAD: opcode 0000011, funct3={~is_mem_sign,mem_size}, I-imm.
  - STORE: opcode 0100011, funct3={0,mem_size}, S-imm; rd ignored.
  - LUI: opcode 0110111, {imm[31:12],rd}.
  - JALR: opcode 1100111, funct3 000, I-imm.
  - ENV: constant 0x00000073; all other fields ignored.
- Illegal (accepted, not pushed, enc_err=1 next cycle, err_count+1):
  - op_class 7.
  - I/S immediate not representable as a 12-bit signed value (imm[31:11] not all-equal).
  - CALC_IMM shift with imm[31:5]≠0.
  - alu_op[3]=1 with f3∉{101} for CALC_IMM, or f3∉{000,101} for CALC_REG.
  - LOAD with mem_size=11, or unsigned with mem_size=10.
  - STORE with mem_size=11.
  - LUI with imm[11:0]≠0.
- Illegal requests are accepted only when in_ready=1; the flow-control rule is the same as for legal requests.
- err_count wraps from all-ones to 0.

Test Plan:
1. After reset, check defaults. Then send CALC_IMM alu_op=0 rd=1 rs1=2 imm=0xFFFFFFFF → out_inst=0xFFF10093 one cycle later. Also send CALC_REG alu_op=1000 rd=3 rs1=1 rs2=2 → 0x402081B3.
2. STORE mem_size=10 rs1=6 rs2=5 imm=-4 → 0xFE532E23. LOAD mem_size=01 is_mem_sign=0 rd=4 rs1=7 imm=8 → 0x0083D203.
3. LUI rd=10 imm=0x12345000 → 0x12345537. CALC_IMM alu_op=1101 rd=1 rs1=1 imm=3 → 0x4030D093. ENV → 0x00000073.
4. With out_ready=0, push 4 legal requests (DEPTH=4) → in_ready=0 after the 4th. Then hold in_valid with out_ready=0 → no accept and out_inst stable. Then release out_ready → 4 words drain in order, one per cycle.
5. Illegal cases: CALC_IMM imm=2048, LOAD mem_size=11, LUI imm=0x1 → each gives a one-cycle enc_err and err_count steps to 3, with no FIFO push. A legal request interleaved between them still emits correctly.
6. Assert reset with 3 words buffered and in_valid high → next cycle out_valid=0, err_count=0, in_ready=1, and the old words never appear.

Source files
------------

// File: rtl/enc.sv
// RV32I instruction encoder: turns a decoded micro-op back into a 32-bit
// instruction word and buffers it in a small output FIFO. Requests that
// cannot be encoded are dropped, flagged and counted.
module enc #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_class,
    input  logic [3:0]       alu_op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    input  logic [1:0]       mem_size,
    input  logic             is_mem_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             enc_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        OP_CALC_IMM = 3'd0,
        OP_CALC_REG = 3'd1,
        OP_LOAD     = 3'd2,
        OP_STORE    = 3'd3,
        OP_LUI      = 3'd4,
        OP_JALR     = 3'd5,
        OP_ENV      = 3'd6,
        OP_RSVD     = 3'd7
    } op_class_e;

    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_REG   = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    op_class_e        cls;
    logic [2:0]       f3;
    logic             imm12_ok;
    logic             is_shift;
    logic [31:0]      inst_d;
    logic             illegal_d;

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             enc_err_q;
    logic [ERR_W-1:0] err_count_q;

    logic             full;
    logic             accept;
    logic             push;
    logic             pop;

    assign cls      = op_class_e'(op_class);
    assign f3       = alu_op[2:0];
    // 12-bit signed immediate is representable when imm[31:11] is a pure sign extension
    assign imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Encode the request and classify it as legal or illegal
    always_comb begin
        inst_d    = '0;
        illegal_d = 1'b0;
        unique case (cls)
            OP_CALC_IMM: begin
                if (is_shift) begin
                    inst_d    = {1'b0, alu_op[3], 5'b00000, imm[4:0], rs1, f3, rd, OPC_IMM};
                    illegal_d = |imm[31:5];
                end else begin
                    inst_d    = {imm[11:0], rs1, f3, rd, OPC_IMM};
                    illegal_d = !imm12_ok;
                end
                if (alu_op[3] && (f3 != 3'b101)) illegal_d = 1'b1;
            end
            OP_CALC_REG: begin
                inst_d    = {1'b0, alu_op[3], 5'b00000, rs2, rs1, f3, rd, OPC_REG};
                illegal_d = alu_op[3] && (f3 != 3'b000) && (f3 != 3'b101);
            end
            OP_LOAD: begin
                inst_d    = {imm[11:0], rs1, ~is_mem_sign, mem_size, rd, OPC_LOAD};
                illegal_d = !imm12_ok || (mem_size == 2'b11) ||
                            (!is_mem_sign && (mem_size == 2'b10));
            end
            OP_STORE: begin
                inst_d    = {imm[11:5], rs2, rs1, 1'b0, mem_size, imm[4:0], OPC_STORE};
                illegal_d = !imm12_ok || (mem_size == 2'b11);
            end
            OP_LUI: begin
                inst_d    = {imm[31:12], rd, OPC_LUI};
                illegal_d = |imm[11:0];
            end
            OP_JALR: begin
                inst_d    = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
                illegal_d = !imm12_ok;
            end
            OP_ENV: begin
                inst_d    = 32'h0000_0073;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    assign full      = (cnt_q == CW'(DEPTH));
    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !illegal_d;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_inst  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign enc_err   = enc_err_q;
    assign err_count = err_count_q;

    // FIFO storage write port; contents are don't-care while not counted as occupied
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= inst_d;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Illegal-request pulse and wrapping drop counter
    always_ff @(posedge clock) begin
        if (reset) begin
            enc_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            enc_err_q <= accept && illegal_d;
            if (accept && illegal_d) err_count_q <= err_count_q + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_enc.sv
// Directed testbench for the RV32I encoder with hand-computed instruction words.
module tb_enc;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_class;
    logic [3:0]  alu_op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [1:0]  mem_size;
    logic        is_mem_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        enc_err;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;

    enc #(.DEPTH(4), .ERR_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .alu_op(alu_op),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_size(mem_size), .is_mem_sign(is_mem_sign),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .enc_err(enc_err), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [2:0] c, input logic [3:0] a, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                           input logic [1:0] ms, input logic sg);
        op_class = c; alu_op = a; rd = d; rs1 = s1; rs2 = s2; imm = im;
        mem_size = ms; is_mem_sign = sg;
    endtask

    // Present one request for a single cycle
    task automatic send(input logic [2:0] c, input logic [3:0] a, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                        input logic [1:0] ms, input logic sg);
        set_req(c, a, d, s1, s2, im, ms, sg);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Send one legal request with out_ready high and check the emitted word
    task automatic one(input string tag, input logic [2:0] c, input logic [3:0] a,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im, input logic [1:0] ms, input logic sg,
                       input logic [31:0] exp);
        send(c, a, d, s1, s2, im, ms, sg);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, out_inst, exp);
        tick();
        check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] fill_exp [4];

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_inst",  out_inst,           32'd0);
        check("rst_enc_err",   {31'd0, enc_err},   32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);

        // basic encodings
        one("addi",  3'd0, 4'b0000, 5'd1,  5'd2, 5'd0, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'hFFF1_0093);
        one("sub",   3'd1, 4'b1000, 5'd3,  5'd1, 5'd2, 32'd0,         2'b00, 1'b0, 32'h4020_81B3);
        one("sw",    3'd3, 4'b0000, 5'd0,  5'd6, 5'd5, 32'hFFFF_FFFC, 2'b10, 1'b0, 32'hFE53_2E23);
        one("lhu",   3'd2, 4'b0000, 5'd4,  5'd7, 5'd0, 32'd8,         2'b01, 1'b0, 32'h0083_D203);
        one("lui",   3'd4, 4'b0000, 5'd10, 5'd0, 5'd0, 32'h1234_5000, 2'b00, 1'b0, 32'h1234_5537);
        one("srai",  3'd0, 4'b1101, 5'd1,  5'd1, 5'd0, 32'd3,         2'b00, 1'b0, 32'h4030_D093);
        one("ecall", 3'd6, 4'b1111, 5'd9,  5'd9, 5'd9, 32'hDEAD_BEEF, 2'b11, 1'b1, 32'h0000_0073);
        one("jalr",  3'd5, 4'b0000, 5'd1,  5'd5, 5'd0, 32'h0000_07FF, 2'b00, 1'b0, 32'h7FF2_80E7);
        one("lb",    3'd2, 4'b0000, 5'd2,  5'd3, 5'd0, 32'hFFFF_F800, 2'b00, 1'b1, 32'h8001_8103);

        // fill the FIFO with the consumer stalled
        out_ready = 1'b0;
        fill_exp[0] = 32'h0050_0093; // addi x1,x0,5
        fill_exp[1] = 32'h0030_9113; // slli x2,x1,3
        fill_exp[2] = 32'h0031_01B3; // add x3,x2,x3
        fill_exp[3] = 32'h0011_A023; // sw x1,0(x3)
        send(3'd0, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5, 2'b00, 1'b0);
        check("fill1_lat", out_inst, fill_exp[0]);
        send(3'd0, 4'b0001, 5'd2, 5'd1, 5'd0, 32'd3, 2'b00, 1'b0);
        send(3'd1, 4'b0000, 5'd3, 5'd2, 5'd3, 32'd0, 2'b00, 1'b0);
        check("fill3_ready", {31'd0, in_ready}, 32'd1);
        send(3'd3, 4'b0000, 5'd0, 5'd3, 5'd1, 32'd0, 2'b10, 1'b0);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        // hold a request while full: nothing accepted, head stable
        set_req(3'd0, 4'b0000, 5'd7, 5'd7, 5'd0, 32'd1, 2'b00, 1'b0);
        in_valid = 1'b1;
        tick(); tick();
        check("full_hold_ready", {31'd0, in_ready}, 32'd0);
        check("full_hold_head",  out_inst, fill_exp[0]);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("drain%0d", i), out_inst, fill_exp[i]);
            tick();
        end
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        check("drain_ready", {31'd0, in_ready},  32'd1);

        // illegal requests, with a legal one interleaved
        send(3'd0, 4'b0000, 5'd1, 5'd1, 5'd0, 32'd2048, 2'b00, 1'b0);
        check("ill1_err",   {31'd0, enc_err},   32'd1);
        check("ill1_cnt",   {16'd0, err_count}, 32'd1);
        check("ill1_nopush", {31'd0, out_valid}, 32'd0);
        tick();
        check("ill1_pulse", {31'd0, enc_err}, 32'd0);
        one("mid_legal", 3'd0, 4'b0000, 5'd5, 5'd6, 5'd0, 32'hFFFF_F800, 2'b00, 1'b0, 32'h8003_0293);
        send(3'd2, 4'b0000, 5'd1, 5'd1, 5'd0, 32'd0, 2'b11, 1'b1);
        check("ill2_err",   {31'd0, enc_err},   32'd1);
        check("ill2_cnt",   {16'd0, err_count}, 32'd2);
        check("ill2_nopush", {31'd0, out_valid}, 32'd0);
        send(3'd4, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd1, 2'b00, 1'b0);
        check("ill3_err",   {31'd0, enc_err},   32'd1);
        check("ill3_cnt",   {16'd0, err_count}, 32'd3);
        check("ill3_nopush", {31'd0, out_valid}, 32'd0);
        send(3'd0, 4'b1000, 5'd1, 5'd1, 5'd0, 32'd0, 2'b00, 1'b0);
        check("ill4_cnt",   {16'd0, err_count}, 32'd4);
        send(3'd0, 4'b0001, 5'd1, 5'd1, 5'd0, 32'd32, 2'b00, 1'b0);
        check("ill5_cnt",   {16'd0, err_count}, 32'd5);
        tick();
        check("ill_done_err", {31'd0, enc_err}, 32'd0);

        // reset with 3 words buffered and a request pending
        out_ready = 1'b0;
        send(3'd0, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd1, 2'b00, 1'b0);
        send(3'd0, 4'b0000, 5'd2, 5'd0, 5'd0, 32'd2, 2'b00, 1'b0);
        send(3'd0, 4'b0000, 5'd3, 5'd0, 5'd0, 32'd3, 2'b00, 1'b0);
        set_req(3'd7, 4'b0000, 5'd4, 5'd0, 5'd0, 32'd4, 2'b00, 1'b0);
        in_valid = 1'b1;
        reset = 1'b1;
        tick();
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_err_count", {16'd0, err_count}, 32'd0);
        check("mrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mrst_enc_err",   {31'd0, enc_err},   32'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mrst_gone%0d", i), {31'd0, out_valid}, 32'd0);
        end
        one("post_rst", 3'd1, 4'b0000, 5'd8, 5'd9, 5'd10, 32'd0, 2'b00, 1'b0, 32'h00A4_8433);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
